// File: rtl/tt_test_chk_pkg.sv
// Shared encodings and helpers for the tt_um_test_chk output checker.
// Imported by the increment tracker and by the checker top.
package tt_test_chk_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACQ  = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;

  localparam logic [7:0] OE_ALL  = 8'hFF;
  localparam logic [7:0] OE_NONE = 8'h00;

  // Expected successor of a counter sample; wraps modulo 256.
  function automatic logic [7:0] next_count(input logic [7:0] v);
    return v + 8'd1;
  endfunction

endpackage

// File: rtl/tt_test_chk_seq.sv
// Count-stream tracker: remembers the previous uo sample, validity flag and
// good-increment run length, and compares the current sample to prev+1.
module tt_test_chk_seq
  import tt_test_chk_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       track,
  input  logic       run_inc,
  input  logic       run_clr,
  input  logic [7:0] uo_mon,
  output logic       inc_ok,
  output logic       inc_bad,
  output logic       wrap,
  output logic [3:0] run
);

  logic [7:0] prev;
  logic       pv;

  // Increment comparison is only meaningful once prev holds a real sample.
  always_comb begin
    inc_ok  = pv && (uo_mon == next_count(prev));
    inc_bad = pv && !inc_ok;
    wrap    = inc_ok && (prev == 8'hFF);
  end

  // prev/pv/run tracking; clear wins so an idle checker never carries a stale sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 8'h00;
      pv   <= 1'b0;
      run  <= 4'd0;
    end else if (clear) begin
      pv  <= 1'b0;
      run <= 4'd0;
    end else begin
      if (track) begin
        prev <= uo_mon;
        pv   <= 1'b1;
      end
      if (run_clr) begin
        run <= 4'd0;
      end else if (run_inc) begin
        run <= run + 4'd1;
      end
    end
  end

endmodule

// File: rtl/tt_um_test_chk.sv
// Checker for the mux's test user design: locks onto the counter stream,
// checks pass-through mirroring and IO enables, counts errors and wraps.
module tt_um_test_chk
  import tt_test_chk_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode_cnt,
  input  logic [7:0]       uio_drv,
  input  logic [7:0]       uo_mon,
  input  logic [7:0]       uio_mon,
  input  logic [7:0]       uio_oe_mon,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [15:0]      wrap_cnt
);

  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_ZERO = {ERR_W{1'b0}};

  logic [1:0] state;
  logic [1:0] state_nx;
  logic       mode_prev;
  logic       in_acq;
  logic       in_lock;
  logic       clear;
  logic       track;
  logic       run_inc;
  logic       run_clr;
  logic       lock_hit;
  logic       settle;
  logic       struct_bad;
  logic       err_now;
  logic       wrap_now;
  logic       inc_ok;
  logic       inc_bad;
  logic       wrap;
  logic [3:0] run;

  tt_test_chk_seq u_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .track   (track),
    .run_inc (run_inc),
    .run_clr (run_clr),
    .uo_mon  (uo_mon),
    .inc_ok  (inc_ok),
    .inc_bad (inc_bad),
    .wrap    (wrap),
    .run     (run)
  );

  // Tracker control derived from the current FSM state.
  always_comb begin
    in_acq   = (state == ST_ACQ);
    in_lock  = (state == ST_LOCK);
    clear    = !mode_cnt || (state == ST_IDLE);
    track    = mode_cnt && (in_acq || in_lock);
    run_inc  = mode_cnt && in_acq && inc_ok;
    run_clr  = mode_cnt && (in_acq || in_lock) && inc_bad;
    lock_hit = run_inc && ((run + 4'd1) == 4'(LOCK_CNT));
  end

  // Leaving counter mode overrides every other transition.
  always_comb begin
    state_nx = state;
    if (!mode_cnt) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nx = ST_ACQ;
        ST_ACQ:  state_nx = lock_hit ? ST_LOCK : ST_ACQ;
        ST_LOCK: state_nx = inc_bad ? ST_ACQ : ST_LOCK;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Structural pin checks, masked on the cycle right after a mode change.
  always_comb begin
    settle = (mode_cnt != mode_prev);
    if (mode_cnt) begin
      struct_bad = (uio_oe_mon != OE_ALL) || (uio_mon != uo_mon);
    end else begin
      struct_bad = (uo_mon != uio_drv) || (uio_oe_mon != OE_NONE) || (uio_mon != 8'h00);
    end
    err_now  = (struct_bad && !settle) || (mode_cnt && in_lock && inc_bad);
    wrap_now = mode_cnt && in_lock && wrap;
  end

  // FSM, mode history and saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_prev <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= ERR_ZERO;
      wrap_cnt  <= 16'h0000;
    end else begin
      state     <= state_nx;
      mode_prev <= mode_cnt;
      locked    <= (state_nx == ST_LOCK);
      err       <= err_now;
      if (err_now && (err_cnt != ERR_MAX)) begin
        err_cnt <= err_cnt + ERR_ONE;
      end
      if (wrap_now && (wrap_cnt != 16'hFFFF)) begin
        wrap_cnt <= wrap_cnt + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_tt_um_test_chk.sv
// Scoreboard bench: a behavioural model predicts each cycle's outputs, a
// monitor compares them one cycle after the sampling edge.
module tb_tt_um_test_chk;

  localparam int LOCK = 4;

  logic        clk;
  logic        rst_n;
  logic        mode_cnt;
  logic [7:0]  uio_drv;
  logic [7:0]  uo_mon;
  logic [7:0]  uio_mon;
  logic [7:0]  uio_oe_mon;
  logic        locked, err, s_locked, s_err;
  logic [15:0] err_cnt, wrap_cnt, s_wrap_cnt;
  logic [1:0]  s_err_cnt;

  tt_um_test_chk #(.LOCK_CNT(LOCK), .ERR_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode_cnt(mode_cnt), .uio_drv(uio_drv),
    .uo_mon(uo_mon), .uio_mon(uio_mon), .uio_oe_mon(uio_oe_mon),
    .locked(locked), .err(err), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
  );

  // Narrow error counter instance to exercise saturation quickly.
  tt_um_test_chk #(.LOCK_CNT(LOCK), .ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .mode_cnt(mode_cnt), .uio_drv(uio_drv),
    .uo_mon(uo_mon), .uio_mon(uio_mon), .uio_oe_mon(uio_oe_mon),
    .locked(s_locked), .err(s_err), .err_cnt(s_err_cnt), .wrap_cnt(s_wrap_cnt)
  );

  typedef struct {
    bit locked;
    bit err;
    int ecnt;
    int wcnt;
    int scnt;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int ph, have, prv, run, mprev, ecnt, scnt, wcnt;
  logic [7:0] c;
  logic       cur_mode;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    ph = 0; have = 0; prv = 0; run = 0; mprev = 0;
    ecnt = 0; scnt = 0; wcnt = 0;
    q.delete();
  endtask

  task automatic model_push(input logic m, input logic [7:0] d, input logic [7:0] u,
                            input logic [7:0] io, input logic [7:0] oe);
    bit sbad, ibad, wr, good;
    exp_t e;
    if (m) sbad = (oe != 8'hFF) || (io != u);
    else   sbad = (u != d) || (oe != 8'h00) || (io != 8'h00);
    if (int'(m) != mprev) sbad = 0;
    ibad = 0; wr = 0;
    if (!m) begin
      ph = 0; have = 0; run = 0;
    end else if (ph == 0) begin
      ph = 1;
    end else begin
      good = (have != 0) && (int'(u) == (prv + 1) % 256);
      if (ph == 2) begin
        if (!good) begin ibad = 1; ph = 1; run = 0; end
        else if (prv == 255) wr = 1;
      end else if (have != 0) begin
        if (good) begin
          run++;
          if (run >= LOCK) ph = 2;
        end else begin
          run = 0;
        end
      end
      prv = int'(u);
      have = 1;
    end
    mprev = int'(m);
    if (sbad || ibad) begin
      if (ecnt < 65535) ecnt++;
      if (scnt < 3) scnt++;
    end
    if (wr && wcnt < 65535) wcnt++;
    e.locked = (ph == 2);
    e.err = sbad || ibad;
    e.ecnt = ecnt;
    e.wcnt = wcnt;
    e.scnt = scnt;
    q.push_back(e);
  endtask

  task automatic drive(input logic m, input logic [7:0] d, input logic [7:0] u,
                       input logic [7:0] io, input logic [7:0] oe);
    @(negedge clk);
    mode_cnt = m; uio_drv = d; uo_mon = u; uio_mon = io; uio_oe_mon = oe;
    model_push(m, d, u, io, oe);
  endtask

  // Clean counter-mode cycle that advances the bench-side counter.
  task automatic cnt_step();
    drive(1'b1, 8'($urandom), c, c, 8'hFF);
    c = c + 8'd1;
  endtask

  // Monitor: compares the DUT against the oldest prediction after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("locked", 32'(locked), 32'(e.locked));
      check("err", 32'(err), 32'(e.err));
      check("err_cnt", 32'(err_cnt), 32'(e.ecnt));
      check("wrap_cnt", 32'(wrap_cnt), 32'(e.wcnt));
      check("sat_err_cnt", 32'(s_err_cnt), 32'(e.scnt));
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, "_wrap_cnt"}, 32'(wrap_cnt), 32'd0);
    check({tag, "_sat_err_cnt"}, 32'(s_err_cnt), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    int k;
    rst_n = 1'b0;
    mode_cnt = 1'b0; uio_drv = 8'h00; uo_mon = 8'h00; uio_mon = 8'h00; uio_oe_mon = 8'h00;
    model_reset();
    c = 8'h00;
    #23;
    check_zero("reset");
    rst_n = 1'b1;

    // Pass-through sweep with a correct mirror, then bit 3 corrupted twice.
    for (int i = 0; i < 256; i++) drive(1'b0, 8'(i), 8'(i), 8'h00, 8'h00);
    for (int i = 0; i < 2; i++) begin
      d = 8'($urandom);
      drive(1'b0, d, d ^ 8'h08, 8'h00, 8'h00);
    end
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      drive(1'b0, d, d, 8'h00, 8'h00);
    end

    // Clean counter from 0x00: lock latency and two wraps.
    c = 8'h00;
    for (int i = 0; i < 600; i++) cnt_step();

    // Single-cycle glitch: 0x37 presented where 0x35 is due.
    while (c != 8'h35) cnt_step();
    drive(1'b1, 8'h00, 8'h37, 8'h37, 8'hFF);
    c = c + 8'd1;
    for (int i = 0; i < 12; i++) cnt_step();

    // IO enables partly dropped for three cycles while the count stays good.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h00, c, c, 8'h7F);
      c = c + 8'd1;
    end
    for (int i = 0; i < 4; i++) cnt_step();

    // Mode toggle 1->0->1: settle cycles carry mismatching pins.
    drive(1'b0, 8'h5A, c, c, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      drive(1'b0, d, d, 8'h00, 8'h00);
    end
    drive(1'b1, 8'h00, c, 8'h00, 8'h00);
    c = c + 8'd1;
    for (int i = 0; i < 10; i++) cnt_step();

    // Randomised mix of mode changes and single-pin faults.
    cur_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) cur_mode = ~cur_mode;
      k = int'($urandom_range(0, 11));
      d = 8'($urandom);
      if (cur_mode) begin
        case (k)
          0: drive(1'b1, d, c ^ 8'(1 << $urandom_range(0, 7)), c, 8'hFF);
          1: drive(1'b1, d, c, c, 8'($urandom));
          2: drive(1'b1, d, c, c ^ 8'h01, 8'hFF);
          default: drive(1'b1, d, c, c, 8'hFF);
        endcase
        c = c + 8'd1;
      end else begin
        case (k)
          0: drive(1'b0, d, d ^ 8'(1 << $urandom_range(0, 7)), 8'h00, 8'h00);
          1: drive(1'b0, d, d, 8'h00, 8'($urandom_range(1, 255)));
          2: drive(1'b0, d, d, 8'($urandom_range(1, 255)), 8'h00);
          default: drive(1'b0, d, d, 8'h00, 8'h00);
        endcase
      end
    end

    // Lock again, then a half-cycle reset mid-lock and a full relock.
    for (int i = 0; i < 12; i++) cnt_step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < LOCK + 6; i++) cnt_step();

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_test_chk.md
# tt_um_test_chk

Simulation-side checker that sits directly downstream of the multiplexer's test user design and consumes its output pins. It watches `uo_out`/`uio_out`/`uio_oe` as returned through the mux and checks them. In pass-through mode, output must mirror the driven `uio_in`. In counter mode, the design must present an 8-bit free-running up-counter on both buses with all IOs enabled. It locks onto the count stream, flags discontinuities, and counts errors and wraps for the bench to read at end of test.

## Interface
Parameters:
- `LOCK_CNT`, default 4: consecutive good increments needed to declare lock (range 1..15).
- `ERR_W`, default 16: width of `err_cnt`.

Ports:
- `clk` input 1: clock, same clock that drives the user design.
- `rst_n` input 1: reset, asynchronous, active-low.
- `mode_cnt` input 1: value the bench drives on `ui_in[0]`; 1 = counter mode, 0 = pass-through.
- `uio_drv` input 8: value the bench drives on `uio_in`.
- `uo_mon` input 8: observed `uo_out`.
- `uio_mon` input 8: observed `uio_out`.
- `uio_oe_mon` input 8: observed `uio_oe`.
- `locked` output 1: counter stream locked.
- `err` output 1: one-cycle pulse per detected error.
- `err_cnt` output ERR_W: saturating error count.
- `wrap_cnt` output 16: saturating count of 0xFF→0x00 transitions seen while locked.

## Operation
- All inputs are sampled at `posedge clk`. `prev` is an 8-bit register of the last sampled `uo_mon`. `pv` flags that `prev` is valid. `run` is a 4-bit good-increment counter.
- FSM states are IDLE, ACQ and LOCK.
  - IDLE: `locked`=0, `pv`=0, `run`=0. With `mode_cnt`=1 the FSM goes to ACQ.
  - ACQ: capture `prev`=`uo_mon` and set `pv`=1.
    - If `pv` and `uo_mon`==`prev`+1 (mod 256): `run`++. When `run` reaches `LOCK_CNT`, go to LOCK.
    - If `pv` and there is a mismatch: `run`=0. No error is counted.
  - LOCK: `locked`=1.
    - Mismatch: `err` is asserted, `err_cnt`++, go to ACQ with `run`=0 and `prev`=`uo_mon`.
    - `prev`==0xFF and `uo_mon`==0x00: `wrap_cnt`++.
  - Any state with `mode_cnt`=0: go to IDLE on the next edge and clear `locked`. Takes priority over all other transitions.
- Structural checks are evaluated every cycle and are independent of the FSM.
  - `mode_cnt`=1: require `uio_oe_mon`==0xFF and `uio_mon`==`uo_mon`.
  - `mode_cnt`=0: require `uo_mon`==`uio_drv`, `uio_oe_mon`==0x00 and `uio_mon`==0x00.
  - Each failing cycle counts as one error. A cycle that fails both the structural check and the LOCK increment check still counts as one error.
- A cycle where `mode_cnt` differs from its previous sampled value is a settle cycle. Structural checks are masked on that cycle only.
- `err_cnt` and `wrap_cnt` saturate at all-ones and never wrap.
- Reset mid-run returns every register to its reset value immediately. No partial state survives.

## Timing
- Reset values: `locked`=0, `err`=0, `err_cnt`=0, `wrap_cnt`=0. FSM is in IDLE, `pv`=0, `run`=0, and the previous-mode register is 0.
- `err`, `err_cnt` and `wrap_cnt` are registered. They reflect a bad sample one cycle after the edge that sampled it.
- `locked` rises one cycle after the edge that sampled the `LOCK_CNT`-th good increment.
  - Minimum latency from `mode_cnt` rising is `LOCK_CNT`+2 edges: 1 edge IDLE→ACQ, 1 edge first capture, `LOCK_CNT` edges of increments.
- `locked` falls one cycle after the edge that sampled a mismatch or `mode_cnt`=0.
- Release of `rst_n` is asynchronous to the checker. The first active sample is the first `posedge clk` with `rst_n`=1.

## Structure
- Shared package (or include) `tt_test_chk_pkg` holds:
  - FSM state encodings ST_IDLE=2'd0, ST_ACQ=2'd1, ST_LOCK=2'd2;
  - the constants OE_ALL=8'hFF and OE_NONE=8'h00.
- One sub-module, `tt_test_chk_seq`, contains the `prev`/`pv`/`run` tracker and the increment comparator. It outputs `inc_ok`, `inc_bad` and `wrap`. The top level owns the FSM, the structural checks and the counters.

## Test plan
- Counter mode, clean counter starting at 0x00, `LOCK_CNT`=4 → `locked`=1 on cycle 6 after `mode_cnt` rises. Then run 600 cycles → `err_cnt`=0 and `wrap_cnt`=2.
- While locked, force `uo_mon`=`uio_mon`=0x37 for one cycle when 0x35 is expected → one `err` pulse, `err_cnt`=1 and `locked` drops. `locked` reasserts 4 good increments later.
- Pass-through mode, `uio_drv` sweeps 0x00..0xFF with a correct mirror → `err_cnt`=0 and `locked`=0 throughout. Then corrupt `uo_mon` bit 3 for 2 cycles → `err_cnt`=2.
- Counter mode with `uio_oe_mon`=0x7F for 3 cycles → `err_cnt`=3, while `locked` stays 1 because the count stream stays good.
- Toggle `mode_cnt` 1→0→1 → the settle cycles produce no error and the FSM returns to IDLE then ACQ. Preload `err_cnt` to 0xFFFE and inject 3 errors → `err_cnt`=0xFFFF.
- Assert `rst_n`=0 mid-lock for half a cycle → all outputs are 0 immediately, and relock takes the full latency after release.
